// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and memory-stage accesses
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_f,
  input  logic              dm_load,
  input  logic              dm_store,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_wstrb,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} stateT;
  stateT state;
  logic [SW-1:0] starveCnt;
  logic [WW-1:0] waitCnt;
  logic flushPending, dmReq, fetchWins, timedOut, flushNow;
  logic [DATA_W-1:0] respData;
  assign dmReq = dm_load | dm_store;
  assign fetchWins = if_req & (~dmReq | (starveCnt == SW'(STARVE_LIMIT)));
  assign timedOut = waitCnt == WW'(TIMEOUT - 1);
  assign flushNow = flushPending | if_flush;
  assign respData = mem_ack ? mem_rdata : '0;
  assign stall_m = dmReq & ~dm_done;
  assign stall_f = (if_req & ~if_valid) | stall_m;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      starveCnt <= '0;
      waitCnt <= '0;
      flushPending <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata <= '0;
      if_valid <= 1'b0;
      dm_rdata <= '0;
      dm_done <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetchWins) begin
            state <= FETCH;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= if_addr;
            mem_wstrb <= 4'hF;
            starveCnt <= '0;
          end else if (dmReq) begin
            state <= DATA;
            mem_req <= 1'b1;
            mem_we <= dm_store;
            mem_addr <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_store ? dm_wstrb : 4'hF;
            // fetchWins is false here, so starveCnt is below the limit and cannot wrap
            if (if_req) starveCnt <= starveCnt + 1'b1;
          end
        end
        FETCH, DATA: begin
          if (state == FETCH && if_flush) flushPending <= 1'b1;
          if (mem_ack || timedOut) begin
            state <= RESP;
            mem_req <= 1'b0;
            waitCnt <= '0;
            bus_err <= bus_err | ~mem_ack;
            if (state == FETCH) begin
              if_valid <= ~flushNow;
              if (!flushNow) if_rdata <= respData;
            end else begin
              dm_done <= 1'b1;
              if (!mem_we) dm_rdata <= respData;
            end
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          if_valid <= 1'b0;
          dm_done <= 1'b0;
          flushPending <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed stimulus checked against a transaction-level model
module tb_mem_port_arbiter;
  localparam int SL = 4;
  localparam int TO = 255;
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 0, if_flush = 0, dm_load = 0, dm_store = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [3:0] dm_wstrb = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_valid, stall_f, dm_done, stall_m, mem_req, mem_we, bus_err;
  logic [3:0] mem_wstrb;
  logic eReq, eWe, eIfValid, eDmDone, eBusErr, busy, resp, isFetch, flushP;
  logic [31:0] eAddr, eWdata, eIfRdata, eDmRdata;
  logic [3:0] eWstrb;
  int starve, waitN, cycles = 0, nCmp = 0, nFail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .stall_f(stall_f), .dm_load(dm_load),
    .dm_store(dm_store), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .stall_m(stall_m), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycles);
    end
  endtask

  task automatic modelReset();
    {eReq, eWe, eIfValid, eDmDone, eBusErr, busy, resp, isFetch, flushP} = '0;
    {eAddr, eWdata, eIfRdata, eDmRdata} = '0;
    eWstrb = 0;
    starve = 0;
    waitN = 0;
  endtask

  // One clock of the arbiter seen as transactions: grant, wait for ack/timeout, one response cycle
  task automatic modelStep();
    logic [31:0] data;
    logic dmR;
    dmR = dm_load | dm_store;
    if (resp) begin
      resp = 0; eIfValid = 0; eDmDone = 0; flushP = 0;
    end else if (busy) begin
      waitN++;
      if (isFetch && if_flush) flushP = 1;
      if (mem_ack || waitN == TO) begin
        data = mem_ack ? mem_rdata : 32'h0;
        if (!mem_ack) eBusErr = 1;
        eReq = 0; busy = 0; resp = 1; waitN = 0;
        if (isFetch) begin
          if (!flushP) begin eIfValid = 1; eIfRdata = data; end
        end else begin
          eDmDone = 1;
          if (!eWe) eDmRdata = data;
        end
      end
    end else if (if_req || dmR) begin
      isFetch = if_req && (!dmR || starve == SL);
      busy = 1; eReq = 1;
      if (isFetch) begin
        starve = 0; eWe = 0; eAddr = if_addr; eWstrb = 4'hF;
      end else begin
        if (if_req && starve < SL) starve++;
        eWe = dm_store; eAddr = dm_addr; eWdata = dm_wdata;
        eWstrb = dm_store ? dm_wstrb : 4'hF;
      end
    end
  endtask

  task automatic compareAll();
    logic dmR;
    dmR = dm_load | dm_store;
    chk("mem_req", mem_req, eReq);
    chk("mem_we", mem_we, eWe);
    chk("mem_addr", mem_addr, eAddr);
    chk("mem_wstrb", mem_wstrb, eWstrb);
    if (eReq && eWe) chk("mem_wdata", mem_wdata, eWdata);
    chk("if_valid", if_valid, eIfValid);
    chk("if_rdata", if_rdata, eIfRdata);
    chk("dm_done", dm_done, eDmDone);
    chk("dm_rdata", dm_rdata, eDmRdata);
    chk("bus_err", bus_err, eBusErr);
    chk("stall_m", stall_m, dmR & ~eDmDone);
    chk("stall_f", stall_f, (if_req & ~eIfValid) | (dmR & ~eDmDone));
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ifa, input logic fl, input logic ld,
                       input logic st, input logic [31:0] da, input logic [31:0] wd,
                       input logic [3:0] ws, input logic ack, input logic [31:0] rd);
    if_req = ifr; if_addr = ifa; if_flush = fl; dm_load = ld; dm_store = st;
    dm_addr = da; dm_wdata = wd; dm_wstrb = ws; mem_ack = ack; mem_rdata = rd;
  endtask

  task automatic settle();
    #1;
    compareAll();
    cycles++;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 0;
    modelReset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    advance();
    rst = 1;
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    doReset();
    chk("rst_bus_err", bus_err, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    // zero-wait fetch
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("f_stall", stall_f, 1); advance();
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'h00500093);
    settle(); chk("f_req", mem_req, 1); chk("f_addr", mem_addr, 32'h100); chk("f_we", mem_we, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("f_valid", if_valid, 1); chk("f_rdata", if_rdata, 32'h00500093); advance();
    // flush while in flight
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(1, 32'h200, 1, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h1234); settle(); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("fl_valid", if_valid, 0); chk("fl_rdata", if_rdata, 32'h00500093); advance();
    settle(); chk("fl_idle", mem_req, 0); advance();
    // starvation: four data grants then a fetch
    drive(1, 32'hB000, 0, 1, 0, 32'hA000, 0, 0, 1, 32'h77);
    for (int c = 0; c < 18; c++) begin
      settle();
      if (c % 3 == 1) chk("starve_addr", mem_addr, (c == 13) ? 32'hB000 : 32'hA000);
      advance();
    end
    // store
    drive(0, 0, 0, 0, 1, 32'h3000, 32'hDEADBEEF, 4'b0011, 0, 0); settle(); advance();
    drive(0, 0, 0, 0, 1, 32'h3000, 32'hDEADBEEF, 4'b0011, 1, 32'h5555);
    settle();
    chk("st_we", mem_we, 1); chk("st_addr", mem_addr, 32'h3000);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF); chk("st_wstrb", mem_wstrb, 4'b0011);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("st_done", dm_done, 1); chk("st_rdata", dm_rdata, 32'h77); advance();
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom % 8;
      drive($urandom_range(0, 1), $urandom, ($urandom % 6) == 0, r == 1 || r == 2 || r == 4,
            r == 3 || r == 4, $urandom, $urandom, 4'($urandom), ($urandom % 3) != 0, $urandom);
      settle();
      advance();
    end
    // timeout then reset mid-transaction
    doReset();
    drive(0, 0, 0, 1, 0, 32'h44, 0, 0, 0, 32'hFFFF);
    settle(); advance();
    for (int i = 1; i <= TO; i++) begin
      settle();
      advance();
    end
    settle();
    chk("to_req", mem_req, 0); chk("to_err", bus_err, 1);
    chk("to_done", dm_done, 1); chk("to_rdata", dm_rdata, 0);
    advance();
    settle(); advance();
    settle(); chk("mid_req", mem_req, 1);
    #2;
    rst = 0;
    #1;
    chk("rst_req", mem_req, 0); chk("rst_err", bus_err, 0);
    modelReset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    rst = 1;
    settle();
    advance();
    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores driven by LoadM/StoreM, ALU_ResultM address, WriteDataM data).
- Registers each granted transaction, holds it on the memory bus until acknowledge or timeout, and returns the read data.
- Generates per-stage stall signals so the pipeline freezes while its access is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants that a pending fetch tolerates before fetch is forced to win.
- TIMEOUT, 255, cycles in a busy state without mem_ack before the transaction is abandoned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch stage requests an instruction read.
- if_addr  input  ADDR_W  fetch address (PC).
- if_flush  input  1  taken branch; any in-flight fetch response is discarded.
- if_rdata  output  DATA_W  fetched instruction.
- if_valid  output  1  one-cycle pulse: if_rdata valid.
- stall_f  output  1  fetch stage must hold.
- dm_load  input  1  memory-stage load.
- dm_store  input  1  memory-stage store.
- dm_addr  input  ADDR_W  data address.
- dm_wdata  input  DATA_W  store data.
- dm_wstrb  input  4  byte enables for stores.
- dm_rdata  output  DATA_W  load result.
- dm_done  output  1  one-cycle pulse: data access complete.
- stall_m  output  1  memory stage (and everything upstream) must hold.
- mem_req  output  1  bus request, held until ack or timeout.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_W  registered bus address.
- mem_wdata  output  DATA_W  registered write data.
- mem_wstrb  output  4  registered byte enables (4'hF for reads).
- mem_rdata  input  DATA_W  bus read data, valid with mem_ack.
- mem_ack  input  1  bus completes the current transaction this cycle.
- bus_err  output  1  sticky; set on any timeout.

Behaviour:
- Reset (async, rst=0): state IDLE; mem_req, mem_we, if_valid, dm_done, bus_err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; mem_wstrb = 0; starve and wait counters = 0; flush_pending = 0. mem_req drops immediately even mid-transaction. No transaction is replayed after reset.
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE:
  - Data request (dm_load|dm_store) wins unless if_req=1 and starve_cnt == STARVE_LIMIT; in that case fetch wins.
  - On grant, latch addr/wdata/wstrb/we into the bus registers; mem_req=1 from the next cycle. Next state is FETCH or DATA.
  - No request: stay in IDLE.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while if_req=1.
  - Clears on every fetch grant.
- FETCH/DATA:
  - Hold mem_req and all bus registers stable and increment the wait counter.
  - On mem_ack: capture mem_rdata, go to RESP, clear the wait counter, drop mem_req at that edge.
  - If the wait counter reaches TIMEOUT without mem_ack: drop mem_req, set bus_err, go to RESP with captured data = 0.
- RESP (exactly one cycle):
  - Pulse if_valid or dm_done per the completed owner.
  - Never grant in RESP, so the requester's still-asserted request is not double-served. RESP always returns to IDLE.
- Stores: mem_we=1, dm_rdata unchanged, dm_done still pulses. dm_load and dm_store both high is treated as a store.
- Minimum latency: request in cycle 0 (IDLE), mem_req in cycle 1, mem_ack in cycle 1, done pulse in cycle 2, next grant possible in cycle 3.
- Stalls (combinational):
  - stall_m = (dm_load|dm_store) & ~dm_done.
  - stall_f = (if_req & ~if_valid) | stall_m.
- Flush:
  - if_flush while in FETCH, or in the same cycle as mem_ack in FETCH: set flush_pending. The bus transaction still completes; in RESP if_valid stays 0 and if_rdata is not updated. flush_pending clears on leaving RESP.
  - if_flush in IDLE/DATA/RESP has no effect on the arbiter.
- Widths: no arithmetic on addresses or data; both counters are sized to their parameter maximum and never wrap.

Test Plan:
- Single fetch, zero-wait: if_req=1, if_addr=0x100, mem_ack in the first bus cycle with mem_rdata=0x00500093. Required: mem_addr=0x100, mem_we=0; if_valid pulses 2 cycles after the request with if_rdata=0x00500093; stall_f high until then.
- Simultaneous fetch and load: dm_load@0x2000 and if_req@0x104, memory with 2 wait states. Required: DATA is granted first; dm_done with dm_rdata=mem_rdata; the fetch is granted 1 cycle after RESP.
- Starvation: if_req held while dm requests are continuous. Required: exactly 4 data grants, then a fetch grant, then the starve counter returns to 0.
- Store: dm_store@0x3000, wdata=0xDEADBEEF, wstrb=4'b0011. Required: mem_we=1, bus values match; dm_done pulses; dm_rdata unchanged.
- Flush in flight: fetch granted, if_flush pulsed while waiting, then ack. Required: no if_valid pulse; if_rdata keeps its previous value; arbiter returns to IDLE.
- Timeout and reset: mem_ack never asserted. Required: after 255 busy cycles mem_req drops, bus_err=1, done pulses with data 0. Then asserting rst mid-transaction clears mem_req and bus_err in the same cycle.
